// File: rtl/sbus_to_axi.sv
// Serialising sbus-slave to AXI3-master bridge issuing single-beat 32-bit transactions.
// Define SBUS_AXI_WBUF_EN to post writes through a one-entry write buffer.
module sbus_to_axi #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sbus_en,
  input  logic [3:0]  sbus_we,
  input  logic [31:0] sbus_addr,
  input  logic [31:0] sbus_wdata,
  output logic [31:0] sbus_rdata,
  output logic        sbus_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

`ifdef SBUS_AXI_WBUF_EN
  localparam bit WbufEn = 1'b1;
`else
  localparam bit WbufEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWaddr, StWresp, StDone} state_t;

  state_t state_q;
  logic   abandoned_q;
  logic   posted_q;
  logic   aw_fin;
  logic   w_fin;
  logic   done_ok;
  logic   post_ok;
  logic   unused_addr_lsb;

  assign unused_addr_lsb = ^sbus_addr[1:0];

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;

  // A channel is finished once its valid has dropped or is handshaking now.
  assign aw_fin = !awvalid || awready;
  assign w_fin  = !wvalid || wready;

  always_comb begin
    done_ok    = (state_q == StDone) && !abandoned_q;
    post_ok    = WbufEn && (state_q == StIdle) && (sbus_we != 4'b0000);
    sbus_stall = sbus_en && !(done_ok || post_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      abandoned_q <= 1'b0;
      posted_q    <= 1'b0;
      sbus_rdata  <= 32'd0;
      araddr      <= 32'd0;
      awaddr      <= 32'd0;
      wdata       <= 32'd0;
      wstrb       <= 4'd0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          abandoned_q <= 1'b0;
          if (sbus_en) begin
            araddr <= {sbus_addr[31:2], 2'b00};
            awaddr <= {sbus_addr[31:2], 2'b00};
            wdata  <= sbus_wdata;
            wstrb  <= sbus_we;
            if (sbus_we == 4'b0000) begin
              arvalid <= 1'b1;
              state_q <= StRaddr;
            end else begin
              awvalid  <= 1'b1;
              wvalid   <= 1'b1;
              posted_q <= WbufEn;
              state_q  <= StWaddr;
            end
          end
        end
        StRaddr: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StRdata;
          end
        end
        StRdata: begin
          if (rvalid) begin
            sbus_rdata <= rdata;
            rready     <= 1'b0;
            state_q    <= StDone;
          end
        end
        StWaddr: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (aw_fin && w_fin) begin
            bready  <= 1'b1;
            state_q <= StWresp;
          end
        end
        StWresp: begin
          if (bvalid) begin
            bready <= 1'b0;
            // A posted write was already acknowledged to the master; just free the buffer.
            if (posted_q) begin
              posted_q <= 1'b0;
              state_q  <= StIdle;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          abandoned_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if ((state_q != StIdle) && (state_q != StDone) && !posted_q && !sbus_en) begin
        abandoned_q <= 1'b1;
      end
    end
  end

endmodule
